// File: rtl/riscv_noc_pkg.sv
// riscv_noc_pkg: shared types and helpers for the NoC router lookup stage.
//   lookup_state_t  per-VC wormhole state (IDLE, WORM, DROP)
//   route_lookup()  routing-table lookup returning a one-hot port mask
package riscv_noc_pkg;

  // Upper bounds the lookup helper supports (OUTPUTS <= 16, DEST_WIDTH <= 8).
  localparam int unsigned LOOKUP_MAX_OUTPUTS  = 16;
  localparam int unsigned LOOKUP_MAX_DEST_W   = 8;
  localparam int unsigned LOOKUP_ROUTES_MAX   = LOOKUP_MAX_OUTPUTS * (2 ** LOOKUP_MAX_DEST_W);
  localparam int unsigned LOOKUP_ROUTES_IDX_W = $clog2(LOOKUP_ROUTES_MAX);
  localparam int unsigned LOOKUP_OUT_IDX_W    = $clog2(LOOKUP_MAX_OUTPUTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORM = 2'd1,
    DROP = 2'd2
  } lookup_state_t;

  // Entry for dest is routes[dest*outputs +: outputs]; only its lowest set bit is kept.
  function automatic logic [LOOKUP_MAX_OUTPUTS-1:0] route_lookup(
    input logic [LOOKUP_ROUTES_MAX-1:0] routes,
    input int unsigned                  outputs,
    input logic [LOOKUP_MAX_DEST_W-1:0] dest
  );
    logic [LOOKUP_MAX_OUTPUTS-1:0] mask;
    logic                          found;
    mask  = '0;
    found = 1'b0;
    for (int unsigned p = 0; p < LOOKUP_MAX_OUTPUTS; p++) begin
      if (p < outputs && !found &&
          routes[LOOKUP_ROUTES_IDX_W'(32'(dest) * outputs + p)]) begin
        mask[LOOKUP_OUT_IDX_W'(p)] = 1'b1;
        found                      = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/riscv_noc_router_lookup_buffer.sv
// riscv_noc_router_lookup_buffer: 2-entry output FIFO of the lookup stage.
//   push/push_*  entry written when push is high (caller guarantees room)
//   full_c       combinational full flag from the registered count
//   out_flit/out_last  head entry fields
//   out_valid    one-hot {channel, port} decode of the head, gated by head-valid
//   out_ready    head pops when the bit matching out_valid is set
module riscv_noc_router_lookup_buffer #(
  parameter int unsigned PLEN     = 64,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUTPUTS  = 7,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PORT_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [PLEN-1:0]              push_flit,
  input  logic                         push_last,
  input  logic [CH_W-1:0]              push_ch,
  input  logic [PORT_W-1:0]            push_port,
  output logic                         full_c,
  output logic [PLEN-1:0]              out_flit,
  output logic                         out_last,
  output logic [CHANNELS*OUTPUTS-1:0]  out_valid,
  input  logic [CHANNELS*OUTPUTS-1:0]  out_ready
);

  logic [PLEN-1:0]   flit_q [2];
  logic [PLEN-1:0]   flit_d [2];
  logic              last_q [2];
  logic              last_d [2];
  logic [CH_W-1:0]   ch_q   [2];
  logic [CH_W-1:0]   ch_d   [2];
  logic [PORT_W-1:0] port_q [2];
  logic [PORT_W-1:0] port_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              head_valid;
  logic              do_pop;
  logic              do_push;

  assign head_valid = (count_q != 2'd0);
  assign full_c     = (count_q == 2'd2);
  assign out_flit   = flit_q[rd_ptr_q];
  assign out_last   = last_q[rd_ptr_q];

  // Head decode to the flat channel*OUTPUTS+port valid vector
  for (genvar c = 0; c < CHANNELS; c++) begin : g_dec_ch
    for (genvar p = 0; p < OUTPUTS; p++) begin : g_dec_port
      assign out_valid[c*OUTPUTS+p] = head_valid &&
                                      (ch_q[rd_ptr_q] == CH_W'(c)) &&
                                      (port_q[rd_ptr_q] == PORT_W'(p));
    end
  end

  assign do_pop  = |(out_valid & out_ready);
  // Push at full is only legal alongside a pop (slot being vacated is the head)
  assign do_push = push && (!full_c || do_pop);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    flit_d   = flit_q;
    last_d   = last_q;
    ch_d     = ch_q;
    port_d   = port_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      flit_d[wr_ptr_q] = push_flit;
      last_d[wr_ptr_q] = push_last;
      ch_d[wr_ptr_q]   = push_ch;
      port_d[wr_ptr_q] = push_port;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q[0] <= '0;
      flit_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      ch_q[0]   <= '0;
      ch_q[1]   <= '0;
      port_q[0] <= '0;
      port_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      flit_q   <= flit_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
      port_q   <= port_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_noc_router_lookup_vc.sv
// riscv_noc_router_lookup_vc: route-lookup stage for one input port with
// CHANNELS virtual channels, one wormhole tracked per channel.
//   in_flit/in_last/in_valid/in_ready  shared flit bus, per-channel handshake
//   out_flit/out_last/out_valid/out_ready  head of the 2-entry output buffer,
//                                         out_valid bit c*OUTPUTS+p = channel c, port p
//   err_drop  one-cycle pulse per channel when an unroutable header is dropped
module riscv_noc_router_lookup_vc
  import riscv_noc_pkg::*;
#(
  parameter int unsigned PLEN       = 64,
  parameter int unsigned OUTPUTS    = 7,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DEST_WIDTH = 5,
  parameter logic [OUTPUTS*(2**DEST_WIDTH)-1:0] ROUTES = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PLEN-1:0]              in_flit,
  input  logic                         in_last,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [PLEN-1:0]              out_flit,
  output logic                         out_last,
  output logic [CHANNELS*OUTPUTS-1:0]  out_valid,
  input  logic [CHANNELS*OUTPUTS-1:0]  out_ready,
  output logic [CHANNELS-1:0]          err_drop
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PORT_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  logic [DEST_WIDTH-1:0]             dest;
  logic [OUTPUTS-1:0]                route;
  logic                              buf_full_c;
  logic [CHANNELS-1:0]               ch_push;
  logic [OUTPUTS-1:0][CHANNELS-1:0]  mask_cols;
  logic [CH_W-1:0][CHANNELS-1:0]     ch_cols;
  logic [PORT_W-1:0][OUTPUTS-1:0]    port_cols;
  logic                              push;
  logic [OUTPUTS-1:0]                push_mask;
  logic [CH_W-1:0]                   push_ch;
  logic [PORT_W-1:0]                 push_port;

  assign dest  = in_flit[PLEN-1 -: DEST_WIDTH];
  assign route = OUTPUTS'(route_lookup(LOOKUP_ROUTES_MAX'(ROUTES), OUTPUTS,
                                       LOOKUP_MAX_DEST_W'(dest)));

  // Per-channel grant, wormhole state machine and drop flag
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lookup_state_t      state_q, state_d;
    logic [OUTPUTS-1:0] port_q, port_d;
    logic               err_q, err_d;
    logic               lower_busy;
    logic               accept;
    logic [OUTPUTS-1:0] mask;

    if (c == 0) begin : g_first
      assign lower_busy = 1'b0;
    end else begin : g_rest
      assign lower_busy = |in_valid[c-1:0];
    end

    // A dropping channel never needs buffer space
    assign in_ready[c] = !lower_busy && (!buf_full_c || state_q == DROP);
    assign accept      = in_valid[c] && in_ready[c];
    assign ch_push[c]  = accept && (state_q == WORM || (state_q == IDLE && route != '0));
    assign mask        = (state_q == WORM) ? port_q : route;
    assign err_drop[c] = err_q;

    for (genvar p = 0; p < OUTPUTS; p++) begin : g_mask
      assign mask_cols[p][c] = ch_push[c] && mask[p];
    end
    for (genvar b = 0; b < CH_W; b++) begin : g_chidx
      assign ch_cols[b][c] = ch_push[c] && (((c >> b) & 1) != 0);
    end

    always_comb begin
      state_d = state_q;
      port_d  = port_q;
      err_d   = 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (route != '0) begin
              if (!in_last) begin
                state_d = WORM;
                port_d  = route;
              end
            end else begin
              err_d = 1'b1;
              if (!in_last) state_d = DROP;
            end
          end
          WORM:    if (in_last) state_d = IDLE;
          DROP:    if (in_last) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        port_q  <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        port_q  <= port_d;
        err_q   <= err_d;
      end
    end
  end

  // Grant makes accepts one-hot, so OR-merging the per-channel terms is a mux
  assign push = |ch_push;
  for (genvar p = 0; p < OUTPUTS; p++) begin : g_pmask
    assign push_mask[p] = |mask_cols[p];
  end
  for (genvar b = 0; b < CH_W; b++) begin : g_pch
    assign push_ch[b] = |ch_cols[b];
  end

  // One-hot port mask to port index
  for (genvar b = 0; b < PORT_W; b++) begin : g_pidx
    for (genvar p = 0; p < OUTPUTS; p++) begin : g_pbit
      assign port_cols[b][p] = push_mask[p] && (((p >> b) & 1) != 0);
    end
    assign push_port[b] = |port_cols[b];
  end

  riscv_noc_router_lookup_buffer #(
    .PLEN     (PLEN),
    .CHANNELS (CHANNELS),
    .OUTPUTS  (OUTPUTS)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_flit (in_flit),
    .push_last (in_last),
    .push_ch   (push_ch),
    .push_port (push_port),
    .full_c    (buf_full_c),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
